// File: rtl/field_scan.sv
// Walks the vector-field RAM in row-major order and hands each non-zero cell
// (pixel-space centre plus vector) to draw_block, one cell at a time.
module field_scan #(
  parameter int FIELD_WIDTH  = 8,
  parameter int FIELD_HEIGHT = 6,
  parameter int FIELD_SIZE   = FIELD_WIDTH * FIELD_HEIGHT,
  parameter int FIELD_ADDRW  = $clog2(FIELD_SIZE),
  parameter int FIELD_DATAW  = 96,
  parameter int BLOCK_SIZE   = 80
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  output logic                   busy,
  output logic                   done,
  output logic [FIELD_ADDRW-1:0] field_addr_read,
  input  logic [FIELD_DATAW-1:0] field_data_out,
  output logic                   blk_start,
  input  logic                   blk_done,
  output logic [31:0]            block_x,
  output logic [31:0]            block_y,
  output logic [31:0]            xn,
  output logic [31:0]            yn,
  output logic [31:0]            mag
);

  localparam int COLW = (FIELD_WIDTH  > 1) ? $clog2(FIELD_WIDTH)  : 1;
  localparam int ROWW = (FIELD_HEIGHT > 1) ? $clog2(FIELD_HEIGHT) : 1;

  localparam logic [COLW-1:0]        COL_LAST  = COLW'(FIELD_WIDTH - 1);
  localparam logic [FIELD_ADDRW-1:0] ADDR_LAST = FIELD_ADDRW'(FIELD_SIZE - 1);
  localparam logic [15:0]            HALF      = 16'(BLOCK_SIZE / 2);
  localparam logic [15:0]            STEP      = 16'(BLOCK_SIZE);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RD   = 3'd1;
  localparam logic [2:0] S_WT   = 3'd2;
  localparam logic [2:0] S_CHK  = 3'd3;
  localparam logic [2:0] S_FIRE = 3'd4;
  localparam logic [2:0] S_DRAW = 3'd5;
  localparam logic [2:0] S_NEXT = 3'd6;
  localparam logic [2:0] S_DONE = 3'd7;

  logic [2:0]             state;
  logic [FIELD_ADDRW-1:0] addr;
  logic [COLW-1:0]        col;
  logic [ROWW-1:0]        row;
  logic [15:0]            cx;
  logic [15:0]            cy;

  // Handshake outputs are pure state decodes, so reset clears them with the FSM.
  assign busy            = (state != S_IDLE);
  assign done            = (state == S_DONE);
  assign blk_start       = (state == S_FIRE);
  assign field_addr_read = addr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      addr    <= '0;
      col     <= '0;
      row     <= '0;
      cx      <= HALF;
      cy      <= HALF;
      block_x <= '0;
      block_y <= '0;
      xn      <= '0;
      yn      <= '0;
      mag     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          addr <= '0;
          col  <= '0;
          row  <= '0;
          cx   <= HALF;
          cy   <= HALF;
          if (start) state <= S_RD;
        end
        S_RD: state <= S_WT;
        S_WT: begin
          xn      <= field_data_out[95:64];
          yn      <= field_data_out[63:32];
          mag     <= field_data_out[31:0];
          block_x <= {cx, 16'h0000};
          block_y <= {cy, 16'h0000};
          state   <= S_CHK;
        end
        S_CHK:  state <= (mag == 32'h0) ? S_NEXT : S_FIRE;
        S_FIRE: state <= S_DRAW;
        S_DRAW: if (blk_done) state <= S_NEXT;
        S_NEXT: begin
          if (addr == ADDR_LAST) begin
            state <= S_DONE;
          end else begin
            // Address and pixel centre advance incrementally; no row*width product.
            addr <= addr + 1'b1;
            if (col == COL_LAST) begin
              col <= '0;
              cx  <= HALF;
              row <= row + 1'b1;
              cy  <= cy + STEP;
            end else begin
              col <= col + 1'b1;
              cx  <= cx + STEP;
            end
            state <= S_RD;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
